// File: rtl/upg_mem_arbiter_if.sv
// Memory-side bus bundle for upg_mem_arbiter: programmer inputs, CPU memory requests
// and the two block RAM ports. The arbiter uses the slave view.
interface upg_mem_arbiter_if #(
    parameter int unsigned DATA_W = 32
);
    logic              upg_wen_i;
    logic [14:0]       upg_adr_i;
    logic [DATA_W-1:0] upg_dat_i;
    logic              upg_done_i;
    logic [13:0]       cpu_iaddr_i;
    logic [13:0]       cpu_daddr_i;
    logic              cpu_dwen_i;
    logic [DATA_W-1:0] cpu_dwdata_i;
    logic [13:0]       imem_addr_o;
    logic              imem_wen_o;
    logic [DATA_W-1:0] imem_wdata_o;
    logic [13:0]       dmem_addr_o;
    logic              dmem_wen_o;
    logic [DATA_W-1:0] dmem_wdata_o;

    modport slave (
        input  upg_wen_i, upg_adr_i, upg_dat_i, upg_done_i,
        input  cpu_iaddr_i, cpu_daddr_i, cpu_dwen_i, cpu_dwdata_i,
        output imem_addr_o, imem_wen_o, imem_wdata_o,
        output dmem_addr_o, dmem_wen_o, dmem_wdata_o
    );

    modport master (
        output upg_wen_i, upg_adr_i, upg_dat_i, upg_done_i,
        output cpu_iaddr_i, cpu_daddr_i, cpu_dwen_i, cpu_dwdata_i,
        input  imem_addr_o, imem_wen_o, imem_wdata_o,
        input  dmem_addr_o, dmem_wen_o, dmem_wdata_o
    );
endinterface

// File: rtl/upg_mem_arbiter.sv
// In-system reprogramming controller: debounces the program button, sequences CPU and
// programmer resets, and steers the instruction/data RAM ports to CPU or programmer.
module upg_mem_arbiter #(
    parameter logic [15:0] DEB_CYC  = 16'd50000,
    parameter int unsigned HOLD_CYC = 4,
    parameter int unsigned DATA_W   = 32
) (
    input  logic              board_clk,
    input  logic              board_rst,
    input  logic              prog_btn,
    upg_mem_arbiter_if.slave  bus,
    output logic              upg_rst_o,
    output logic              cpu_rst_o,
    output logic              prog_active_o,
    output logic [15:0]       word_cnt_o
);
    localparam int unsigned HoldW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HoldW-1:0] HoldInit = HoldW'(HOLD_CYC - 1);

    typedef enum logic [1:0] {StHold, StRun, StProg} state_e;

    state_e            state_q, state_d;
    logic [HoldW-1:0]  hold_cnt_q, hold_cnt_d;
    logic              done_prev_q, done_prev_d;
    logic [15:0]       word_cnt_q, word_cnt_d;
    logic [1:0]        btn_sync_q;
    logic              deb_level_q, deb_level_d;
    logic [15:0]       deb_cnt_q, deb_cnt_d;
    logic              press;
    logic [DATA_W-1:0] prog_wdata;

    assign prog_wdata = bus.upg_dat_i;
    assign word_cnt_o = word_cnt_q;

    // Level flips once the synchronized input has disagreed for DEB_CYC straight cycles.
    always_comb begin
        deb_level_d = deb_level_q;
        deb_cnt_d   = '0;
        press       = 1'b0;
        if (btn_sync_q[1] != deb_level_q) begin
            if (deb_cnt_q == DEB_CYC - 16'd1) begin
                deb_level_d = ~deb_level_q;
                press       = ~deb_level_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge board_clk or posedge board_rst) begin
        if (board_rst) begin
            btn_sync_q  <= 2'b00;
            deb_level_q <= 1'b0;
            deb_cnt_q   <= '0;
        end else begin
            btn_sync_q  <= {btn_sync_q[0], prog_btn};
            deb_level_q <= deb_level_d;
            deb_cnt_q   <= deb_cnt_d;
        end
    end

    always_ff @(posedge board_clk or posedge board_rst) begin
        if (board_rst) begin
            state_q     <= StHold;
            hold_cnt_q  <= HoldInit;
            done_prev_q <= 1'b0;
            word_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            done_prev_q <= done_prev_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        done_prev_d = done_prev_q;
        word_cnt_d  = word_cnt_q;
        case (state_q)
            StHold: begin
                if (hold_cnt_q == '0) begin
                    state_d = StRun;
                end else begin
                    hold_cnt_d = hold_cnt_q - HoldW'(1);
                end
            end
            StRun: begin
                if (press) begin
                    state_d     = StProg;
                    word_cnt_d  = '0;
                    // Treat done as already high so a stale level cannot end the session.
                    done_prev_d = 1'b1;
                end
            end
            StProg: begin
                done_prev_d = bus.upg_done_i;
                if (bus.upg_wen_i && (word_cnt_q != 16'hFFFF)) begin
                    word_cnt_d = word_cnt_q + 16'd1;
                end
                if (bus.upg_done_i && !done_prev_q) begin
                    state_d    = StHold;
                    hold_cnt_d = HoldInit;
                end
            end
            default: state_d = StHold;
        endcase
    end

    always_comb begin
        upg_rst_o        = 1'b1;
        cpu_rst_o        = 1'b1;
        prog_active_o    = 1'b0;
        bus.imem_addr_o  = bus.cpu_iaddr_i;
        bus.imem_wen_o   = 1'b0;
        bus.imem_wdata_o = prog_wdata;
        bus.dmem_addr_o  = bus.cpu_daddr_i;
        bus.dmem_wen_o   = 1'b0;
        bus.dmem_wdata_o = bus.cpu_dwdata_i;
        case (state_q)
            StRun: begin
                cpu_rst_o      = 1'b0;
                bus.dmem_wen_o = bus.cpu_dwen_i;
            end
            StProg: begin
                upg_rst_o        = 1'b0;
                prog_active_o    = 1'b1;
                bus.imem_addr_o  = bus.upg_adr_i[13:0];
                bus.dmem_addr_o  = bus.upg_adr_i[13:0];
                bus.dmem_wdata_o = prog_wdata;
                bus.imem_wen_o   = bus.upg_wen_i & ~bus.upg_adr_i[14];
                bus.dmem_wen_o   = bus.upg_wen_i & bus.upg_adr_i[14];
            end
            default: ;
        endcase
    end
endmodule

// File: doc/upg_mem_arbiter.md
Name: upg_mem_arbiter

Overview:
- Controls in-system reprogramming of the CPU instruction and data block RAMs through the UART programmer.
- Debounces the program-mode button and drives the programmer reset. Holds the CPU in reset while a programming session runs.
- Steers each RAM port to either the CPU or the programmer, and decodes programmer writes into imem or dmem by address bit 14.
- Sits between the UART programmer, the CPU memory interfaces and the two block RAMs.

Parameters:
- DEB_CYC, 16'd50000: consecutive stable cycles before a button level change is accepted.
- HOLD_CYC, 4: cycles cpu_rst_o stays high after programming ends or after board_rst release (must be ≥1).
- DATA_W, 32: memory data width.

Ports:
- board_clk  in  1  system clock; all upg_* inputs are synchronous to it.
- board_rst  in  1  asynchronous, active-high reset.
- prog_btn  in  1  raw program-mode button, asynchronous to board_clk.
- upg_wen_i  in  1  programmer write strobe.
- upg_adr_i  in  15  programmer word address; bit 14 selects dmem(1) or imem(0).
- upg_dat_i  in  DATA_W  programmer write data.
- upg_done_i  in  1  programmer finished flag.
- cpu_iaddr_i  in  14  CPU instruction fetch word address.
- cpu_daddr_i  in  14  CPU data word address.
- cpu_dwen_i  in  1  CPU data write enable.
- cpu_dwdata_i  in  DATA_W  CPU data write data.
- imem_addr_o  out  14  imem address.
- imem_wen_o  out  1  imem write enable.
- imem_wdata_o  out  DATA_W  imem write data.
- dmem_addr_o  out  14  dmem address.
- dmem_wen_o  out  1  dmem write enable.
- dmem_wdata_o  out  DATA_W  dmem write data.
- upg_rst_o  out  1  programmer reset, active-high.
- cpu_rst_o  out  1  CPU reset, active-high.
- prog_active_o  out  1  high while state==PROG.
- word_cnt_o  out  16  programmer writes accepted in the current or last session.

Behaviour:
- Reset (async, board_rst=1) values:
  - state=HOLD, hold counter=HOLD_CYC-1.
  - upg_rst_o=1, cpu_rst_o=1, prog_active_o=0, word_cnt_o=0.
  - Debouncer level=0, debounce counter=0.
- Button path:
  - 2-flop synchronizer on prog_btn.
  - Debounced level flips only after the synchronized value has differed from it for DEB_CYC consecutive cycles. Any bounce back clears the counter.
  - Press event = one-cycle pulse on a debounced 0→1 transition.
- FSM, state registered:
  - HOLD:
    - upg_rst_o=1, cpu_rst_o=1.
    - Counter decrements each cycle; at 0 → RUN.
    - Press events are ignored.
  - RUN:
    - upg_rst_o=1, cpu_rst_o=0.
    - Press event → PROG; on that same edge word_cnt_o←0 and done_prev←1.
  - PROG:
    - upg_rst_o=0, cpu_rst_o=1, prog_active_o=1.
    - Rising edge of upg_done_i (upg_done_i=1 and done_prev=0) → HOLD with counter=HOLD_CYC-1.
    - A done level already high on entry is ignored until it drops and rises again.
    - Press events are ignored.
- done_prev register: ←upg_done_i every cycle in PROG.
- Port steering is combinational on the state register, with zero added latency.
  - State≠PROG:
    - imem_addr_o=cpu_iaddr_i, imem_wen_o=0.
    - dmem_addr_o=cpu_daddr_i, dmem_wdata_o=cpu_dwdata_i.
    - dmem_wen_o=cpu_dwen_i only in RUN, forced 0 in HOLD.
  - State==PROG:
    - Both addresses=upg_adr_i[13:0]; both wdata=upg_dat_i.
    - imem_wen_o=upg_wen_i & ~upg_adr_i[14].
    - dmem_wen_o=upg_wen_i & upg_adr_i[14].
    - CPU write inputs are ignored.
  - imem_wdata_o=upg_dat_i in all states.
- word_cnt_o:
  - Increments by 1 on each cycle with upg_wen_i=1 in PROG.
  - Saturates at 16'hFFFF.
  - Holds its value outside PROG until the next PROG entry.
- upg_wen_i outside PROG has no effect on outputs or counters.
- board_rst mid-session: immediate return to reset values, with no further RAM writes from that edge.

Test Plan:
- Reset release with HOLD_CYC=4 → cpu_rst_o stays 1 for exactly 4 board_clk edges after release, then 0; upg_rst_o stays 1.
- Button bouncing (DEB_CYC=8, high pulses of 3 cycles then stable high) → exactly one PROG entry, 10 cycles after the stable level begins (2 sync + 8 stable); upg_rst_o 1→0, cpu_rst_o 0→1.
- In PROG, writes to 15'h0005 (data A5A5A5A5) and 15'h4003 (data 12345678) → imem_wen_o pulses with address 5; dmem_wen_o pulses with address 3 and its data; word_cnt_o=2.
- upg_done_i held high on PROG entry, then low, then high → FSM leaves PROG only on the second rise; cpu_rst_o falls HOLD_CYC cycles later.
- In RUN, cpu_dwen_i=1 and upg_wen_i=1 at 15'h0001 → dmem_wen_o follows the CPU write; imem_wen_o=0; word_cnt_o unchanged. Press during HOLD → ignored.
- board_rst asserted mid-PROG while upg_wen_i=1 → imem_wen_o and dmem_wen_o go 0 immediately; state=HOLD; word_cnt_o=0.
